// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, digit code table and FSM states for the display driver
package display_pkg;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    CARREGA
  } estado_t;

  // Active-low segment pattern (g..a) for one BCD digit; non-decimal nibbles stay dark
  function automatic logic [6:0] codigo_segmentos(input logic [3:0] digito);
    logic [6:0] seg;
    case (digito)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_APAGADO;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/binario_para_displays_if.sv
// rtl/binario_para_displays_if.sv - request/result bundle between the datapath and the display driver
interface binario_para_displays_if #(
  parameter int N_DIGITOS = 6,
  parameter int LARGURA   = 20
);

  logic                     inicio;
  logic [LARGURA-1:0]       numero;
  logic                     suprimir_zeros;
  logic                     apagar;
  logic                     ocupado;
  logic                     pronto;
  logic                     estouro;
  logic [7*N_DIGITOS-1:0]   segmentos;

  modport master (
    output inicio, numero, suprimir_zeros, apagar,
    input  ocupado, pronto, estouro, segmentos
  );

  modport slave (
    input  inicio, numero, suprimir_zeros, apagar,
    output ocupado, pronto, estouro, segmentos
  );

endinterface

// File: rtl/conversor_double_dabble.sv
// rtl/conversor_double_dabble.sv - iterative shift-add-3 binary to BCD engine with overflow tracking
module conversor_double_dabble #(
  parameter int LARGURA   = 20,
  parameter int N_DIGITOS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     carregar_i,
  input  logic                     deslocar_i,
  input  logic [LARGURA-1:0]       numero_i,
  output logic [4*N_DIGITOS-1:0]   bcd_o,
  output logic                     estouro_o,
  output logic                     ultimo_o
);

  localparam int CW = $clog2(LARGURA + 1);

  logic [LARGURA-1:0]     bin_q, bin_d;
  logic [4*N_DIGITOS-1:0] bcd_q, bcd_d;
  logic [4*N_DIGITOS-1:0] ajustado;
  logic                   ovf_q, ovf_d;
  logic [CW-1:0]          cont_q, cont_d;

  // One double-dabble step: fix up nibbles >=5, then shift; a 1 leaving the top digit means overflow
  always_comb begin
    ajustado = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      ajustado[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    cont_d = cont_q;
    if (carregar_i) begin
      bin_d  = numero_i;
      bcd_d  = '0;
      ovf_d  = 1'b0;
      cont_d = CW'(LARGURA);
    end else if (deslocar_i) begin
      bcd_d  = {ajustado[4*N_DIGITOS-2:0], bin_q[LARGURA-1]};
      bin_d  = {bin_q[LARGURA-2:0], 1'b0};
      ovf_d  = ovf_q | ajustado[4*N_DIGITOS-1];
      cont_d = cont_q - CW'(1);
    end
  end

  // Shift register, BCD accumulator, overflow flag and remaining-shift counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      cont_q <= '0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      cont_q <= cont_d;
    end
  end

  assign bcd_o     = bcd_q;
  assign estouro_o = ovf_q;
  assign ultimo_o  = (cont_q == CW'(1));

endmodule

// File: rtl/binario_para_displays.sv
// rtl/binario_para_displays.sv - multi-digit 7-segment driver: conversion FSM, zero suppression, display register
module binario_para_displays
  import display_pkg::*;
#(
  parameter int N_DIGITOS = 6,
  parameter int LARGURA   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  binario_para_displays_if.slave bus
);

  estado_t                estado_q;
  logic                   supr_q;
  logic                   ocupado_q;
  logic                   pronto_q;
  logic                   estouro_q;
  logic [7*N_DIGITOS-1:0] display_q;
  logic [7*N_DIGITOS-1:0] display_d;

  logic                   carregar;
  logic                   deslocar;
  logic [4*N_DIGITOS-1:0] bcd;
  logic                   estouro_conv;
  logic                   ultimo;

  assign carregar = (estado_q == OCIOSO) && bus.inicio;
  assign deslocar = (estado_q == CONVERTE);

  conversor_double_dabble #(
    .LARGURA   (LARGURA),
    .N_DIGITOS (N_DIGITOS)
  ) u_conversor (
    .clk        (clk),
    .reset      (reset),
    .carregar_i (carregar),
    .deslocar_i (deslocar),
    .numero_i   (bus.numero),
    .bcd_o      (bcd),
    .estouro_o  (estouro_conv),
    .ultimo_o   (ultimo)
  );

  // Segment image for the finished conversion: dashes on overflow, else digits with optional leading blanks
  always_comb begin
    logic       zeros_acima;
    logic [3:0] digito;
    display_d   = '0;
    zeros_acima = 1'b1;
    digito      = '0;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      digito = bcd[4*i +: 4];
      if (digito != 4'd0) zeros_acima = 1'b0;
      if (estouro_conv)                        display_d[7*i +: 7] = SEG_TRACO;
      else if (supr_q && zeros_acima && i != 0) display_d[7*i +: 7] = SEG_APAGADO;
      else                                      display_d[7*i +: 7] = codigo_segmentos(digito);
    end
  end

  // Control FSM with registered status outputs and the display register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      supr_q    <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
      display_q <= {N_DIGITOS{SEG_APAGADO}};
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (bus.inicio) begin
            supr_q    <= bus.suprimir_zeros;
            ocupado_q <= 1'b1;
            estado_q  <= CONVERTE;
          end
        end
        CONVERTE: begin
          if (ultimo) estado_q <= CARREGA;
        end
        CARREGA: begin
          display_q <= display_d;
          estouro_q <= estouro_conv;
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.estouro   = estouro_q;
  assign bus.segmentos = bus.apagar ? {N_DIGITOS{SEG_APAGADO}} : display_q;

endmodule

// File: doc/binario_para_displays.md
Name: binario_para_displays

Overview:
Parametrised multi-digit 7-segment driver. Takes an unsigned binary value on a start pulse and converts it to BCD with an iterative shift-add-3 (double dabble) engine. It then latches active-low segment patterns for N digits into a display register. Adds leading-zero suppression, overflow indication and a blank override; sits between datapath results and the board HEX displays.

Parameters:
N_DIGITOS, 6, number of 7-segment digits driven (legal 1..8)
LARGURA, 20, width of the binary input in bits (legal 4..32)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
inicio  in  1  start pulse; accepted only when ocupado=0
numero  in  LARGURA  unsigned binary value, sampled on the accepting edge
suprimir_zeros  in  1  leading-zero suppression enable, sampled with numero
apagar  in  1  blank override, combinational, zero latency
ocupado  out  1  high while a conversion is in progress
pronto  out  1  one-cycle pulse when the display register is updated
estouro  out  1  high when the last converted value exceeded 10^N_DIGITOS-1
segmentos  out  7*N_DIGITOS  active-low segments (bit order g..a); digit 0 (least significant) is [6:0]

Behaviour:
- Reset (async, any state): FSM→OCIOSO, ocupado=0, pronto=0, estouro=0, display register all 7'b1111111. An in-flight conversion is discarded.
- FSM states: OCIOSO, CONVERTE, CARREGA.
- OCIOSO: when inicio=1, capture numero and suppression flag into the shift register, clear BCD and overflow accumulators, set counter=LARGURA, go to CONVERTE. This is edge 0.
- CONVERTE: on each edge:
  - add 3 to every BCD nibble >=5;
  - shift {BCD,bin} left by 1;
  - any 1 shifted out of the top nibble sets the internal overflow flag;
  - decrement the counter.
  - After LARGURA shifts (edges 1..LARGURA), go to CARREGA.
- CARREGA (edge LARGURA+1): write the display register, update estouro, assert pronto for the following cycle only, return to OCIOSO.
- ocupado is high from after edge 0 up to and including the cycle before edge LARGURA+1. A new inicio is accepted in the cycle pronto is high (back-to-back throughput = LARGURA+2 cycles).
- inicio while ocupado=1: ignored, no queuing.
- Digit encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 (unreachable) encodes as 1111111
- Overflow: all digits show dash 7'b0111111 and estouro=1. Suppression does not apply.
- Suppression on: every digit above the most significant nonzero digit is 1111111. A value of 0 shows a single "0" on digit 0.
- apagar=1 forces all segmentos to 1111111 combinationally. The display register and FSM are unaffected; releasing apagar shows the stored value.
- Display register holds its value between conversions; only CARREGA or reset change it.

Decomposition:
- Shared package (display_pkg):
  - constants SEG_APAGADO=7'b1111111, SEG_TRACO=7'b0111111;
  - the digit-to-segment code table as a function;
  - FSM state typedef.
- One natural sub-module: conversor_double_dabble (parametrised by LARGURA, N_DIGITOS). It owns the shift register, counter and overflow detection, and presents BCD digits plus an overflow flag. The top level holds the FSM, suppression, display register and apagar mux.

Test Plan (LARGURA=20, N_DIGITOS=6):
- numero=123456, inicio pulse → pronto exactly 21 edges after acceptance; segmentos[41:35]=1111001 ... [6:0]=0000010; estouro=0.
- numero=42, suprimir_zeros=1 → digits 5..2 = 1111111, digit1=0011001, digit0=0100100. Same value with suprimir_zeros=0 → digits 5..2 = 1000000.
- numero=0, suprimir_zeros=1 → only digit0=1000000, others blank. numero=1048575 → all digits 0111111, estouro=1; a following conversion of 7 clears estouro.
- Second inicio mid-conversion (edge 5) → ignored; result and pronto timing match the first value. inicio held during the pronto cycle → new conversion starts immediately.
- reset asserted at edge 10 of a conversion → ocupado, pronto, estouro 0 immediately; segmentos all 1111111; no pronto afterwards.
- apagar=1 after displaying 123456 → all 1111111 same cycle; apagar=0 → 123456 pattern restored without reconversion.
